// File: rtl/tile_map_pkg.sv
// Shared types, grid geometry and the built-in map-0 layout for the tile map engine.
package tile_map_pkg;

  localparam int GRID_W   = 12;
  localparam int GRID_H   = 12;
  localparam int NUM_MAPS = 4;
  localparam int RANGE_W  = 3;
  localparam int MAP_W    = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    WALL  = 2'b01,
    BRICK = 2'b10
  } tile_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    BLAST,
    DONE
  } state_t;

  // Ray order during a blast; the engine steps through these in declaration order.
  typedef enum logic [1:0] {
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_t;

  // Leftmost character of each row literal is column 0.
  localparam logic [GRID_W-1:0] MAP0_WALL [GRID_H] = '{
    12'b111111111111,
    12'b100000000001,
    12'b101110011101,
    12'b101000000101,
    12'b101010110101,
    12'b100010000001,
    12'b100000010001,
    12'b101011010101,
    12'b101000000101,
    12'b101110011101,
    12'b100000000001,
    12'b111111111111
  };

  localparam logic [GRID_W-1:0] MAP0_BRICK [GRID_H] = '{
    12'b000000000000,
    12'b000110000000,
    12'b000000000000,
    12'b000000000000,
    12'b000000000000,
    12'b000000000000,
    12'b000000000000,
    12'b000000000000,
    12'b000000000000,
    12'b000000000000,
    12'b000000011000,
    12'b000000000000
  };

  // A cell flagged as both wall and brick in a ROM row is a wall.
  function automatic tile_t decode_cell(input logic wall, input logic brick);
    if (wall) return WALL;
    if (brick) return BRICK;
    return EMPTY;
  endfunction

  // Unknown layout numbers fall back to map 0.
  function automatic logic [MAP_W-1:0] map_sel(input logic [3:0] idx);
    if (idx < 4'(NUM_MAPS)) return idx[MAP_W-1:0];
    return '0;
  endfunction

endpackage

// File: rtl/tile_map_engine_if.sv
// Request/status bus between the game-state controller and the tile map engine.
interface tile_map_engine_if;
  import tile_map_pkg::*;

  logic               load_start;
  logic [3:0]         map_index;
  logic               load_busy;
  logic               blast_valid;
  logic               blast_ready;
  logic [3:0]         blast_row;
  logic [3:0]         blast_col;
  logic [RANGE_W-1:0] blast_range;
  logic               blast_done;
  logic [7:0]         bricks_destroyed;

  modport master (
    output load_start, map_index, blast_valid, blast_row, blast_col, blast_range,
    input  load_busy, blast_ready, blast_done, bricks_destroyed
  );

  modport slave (
    input  load_start, map_index, blast_valid, blast_row, blast_col, blast_range,
    output load_busy, blast_ready, blast_done, bricks_destroyed
  );

endinterface

// File: rtl/tile_map_rom.sv
// Layout ROM: returns the wall and brick bitmaps of one row of the selected map.
// Map 1 is a bordered arena with brick bands, map 2 the map-0 walls with no
// bricks, map 3 the map-0 walls with every open cell bricked.
module tile_map_rom
  import tile_map_pkg::*;
(
  input  logic [MAP_W-1:0]  i_map,
  input  logic [3:0]        i_row,
  output logic [GRID_W-1:0] o_wall_row,
  output logic [GRID_W-1:0] o_brick_row
);

  localparam logic [GRID_W-1:0] BORDER_ROW = {1'b1, {(GRID_W-2){1'b0}}, 1'b1};
  localparam logic [GRID_W-1:0] BAND_ROW   = 12'b001111111100;

  logic w_edge_row;
  logic w_band_row;

  assign w_edge_row = (i_row == 4'd0) || (i_row == 4'(GRID_H - 1));
  assign w_band_row = !i_row[0] && (i_row >= 4'd2) && (i_row <= 4'd8);

  // Row lookup; rows beyond the grid read as empty.
  always_comb begin
    o_wall_row  = '0;
    o_brick_row = '0;
    if (i_row < 4'(GRID_H)) begin
      case (i_map)
        2'd1: begin
          o_wall_row  = w_edge_row ? '1 : BORDER_ROW;
          o_brick_row = w_band_row ? BAND_ROW : '0;
        end
        2'd2: begin
          o_wall_row  = MAP0_WALL[i_row];
        end
        2'd3: begin
          o_wall_row  = MAP0_WALL[i_row];
          o_brick_row = '1;
        end
        default: begin
          o_wall_row  = MAP0_WALL[i_row];
          o_brick_row = MAP0_BRICK[i_row];
        end
      endcase
    end
  end

endmodule

// File: rtl/tile_map_engine.sv
// Tile map engine: mutable tile grid loaded from the layout ROM, two
// combinational read ports, and a bomb-blast sequencer that clears bricks
// one ray cell per cycle (up, down, left, right).
module tile_map_engine
  import tile_map_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_reset,
  tile_map_engine_if.slave         bus,
  input  logic [3:0]               i_rd_row_a,
  input  logic [3:0]               i_rd_col_a,
  output logic [1:0]               o_tile_a,
  input  logic [3:0]               i_rd_row_b,
  input  logic [3:0]               i_rd_col_b,
  output logic [1:0]               o_tile_b,
  output logic [GRID_W*GRID_H-1:0] o_wall_map_out
);

  state_t             r_state;
  state_t             w_next_state;
  tile_t              r_grid [GRID_H][GRID_W];
  logic [3:0]         r_row;
  logic [MAP_W-1:0]   r_map;
  logic [3:0]         r_b_row;
  logic [3:0]         r_b_col;
  logic [RANGE_W-1:0] r_range;
  logic [RANGE_W-1:0] r_step;
  dir_t               r_dir;
  logic [7:0]         r_count;
  logic               r_done;

  logic [GRID_W-1:0]  w_rom_wall;
  logic [GRID_W-1:0]  w_rom_brick;
  logic [5:0]         w_tgt_row;
  logic [5:0]         w_tgt_col;
  logic               w_tgt_in;
  tile_t              w_tgt_cell;
  logic               w_ray_end;
  logic               w_clear;
  logic               w_load_req;
  logic               w_accept;

  tile_map_rom u_rom (
    .i_map       (r_map),
    .i_row       (r_row),
    .o_wall_row  (w_rom_wall),
    .o_brick_row (w_rom_brick)
  );

  // Cell under examination: centre offset by the current step along the current ray.
  // Six-bit arithmetic lets an underflow wrap to a large value that fails the bounds test.
  always_comb begin
    w_tgt_row = {2'b00, r_b_row};
    w_tgt_col = {2'b00, r_b_col};
    case (r_dir)
      DIR_UP:   w_tgt_row = {2'b00, r_b_row} - {3'b000, r_step};
      DIR_DOWN: w_tgt_row = {2'b00, r_b_row} + {3'b000, r_step};
      DIR_LEFT: w_tgt_col = {2'b00, r_b_col} - {3'b000, r_step};
      default:  w_tgt_col = {2'b00, r_b_col} + {3'b000, r_step};
    endcase
  end

  assign w_tgt_in   = (w_tgt_row < 6'(GRID_H)) && (w_tgt_col < 6'(GRID_W));
  assign w_tgt_cell = w_tgt_in ? r_grid[w_tgt_row[3:0]][w_tgt_col[3:0]] : WALL;

  // FSM state register; reset aborts any load or blast and restarts loading map 0.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= LOAD;
    else         r_state <= w_next_state;
  end

  // Next-state and per-cycle control; a load request beats a simultaneous blast.
  always_comb begin
    w_next_state = r_state;
    w_ray_end    = 1'b0;
    w_clear      = 1'b0;
    w_load_req   = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.load_start) begin
          w_load_req   = 1'b1;
          w_next_state = LOAD;
        end else if (bus.blast_valid) begin
          w_accept     = 1'b1;
          w_next_state = (bus.blast_range == '0) ? DONE : BLAST;
        end
      end
      LOAD: begin
        if (r_row == 4'(GRID_H - 1)) w_next_state = IDLE;
      end
      BLAST: begin
        w_clear   = w_tgt_in && (w_tgt_cell == BRICK);
        w_ray_end = !w_tgt_in || (w_tgt_cell != EMPTY) || (r_step == r_range);
        if (w_ray_end && (r_dir == DIR_RIGHT)) w_next_state = DONE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign bus.load_busy        = (r_state == LOAD);
  assign bus.blast_ready      = (r_state == IDLE);
  assign bus.blast_done       = r_done;
  assign bus.bricks_destroyed = r_count;

  // Grid, load row counter, blast bookkeeping and the brick counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int r = 0; r < GRID_H; r++) begin
        for (int c = 0; c < GRID_W; c++) begin
          r_grid[r][c] <= EMPTY;
        end
      end
      r_row   <= '0;
      r_map   <= '0;
      r_b_row <= '0;
      r_b_col <= '0;
      r_range <= '0;
      r_step  <= RANGE_W'(1);
      r_dir   <= DIR_UP;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= (r_state == DONE);

      if (r_state == LOAD) begin
        for (int c = 0; c < GRID_W; c++) begin
          r_grid[r_row][c] <= decode_cell(w_rom_wall[GRID_W-1-c], w_rom_brick[GRID_W-1-c]);
        end
        r_row   <= r_row + 4'd1;
        r_count <= '0;
      end

      if (w_load_req) begin
        r_map <= map_sel(bus.map_index);
        r_row <= '0;
      end

      if (w_accept) begin
        r_b_row <= bus.blast_row;
        r_b_col <= bus.blast_col;
        r_range <= bus.blast_range;
        r_step  <= RANGE_W'(1);
        r_dir   <= DIR_UP;
      end

      if (w_clear) begin
        r_grid[w_tgt_row[3:0]][w_tgt_col[3:0]] <= EMPTY;
        if (r_count != 8'hFF) r_count <= r_count + 8'd1;
      end

      if (r_state == BLAST) begin
        if (w_ray_end) begin
          r_dir  <= dir_t'(r_dir + 2'd1);
          r_step <= RANGE_W'(1);
        end else begin
          r_step <= r_step + RANGE_W'(1);
        end
      end
    end
  end

  // Read ports; anything outside the grid reads as wall.
  always_comb begin
    o_tile_a = WALL;
    o_tile_b = WALL;
    if ((i_rd_row_a < 4'(GRID_H)) && (i_rd_col_a < 4'(GRID_W))) o_tile_a = r_grid[i_rd_row_a][i_rd_col_a];
    if ((i_rd_row_b < 4'(GRID_H)) && (i_rd_col_b < 4'(GRID_W))) o_tile_b = r_grid[i_rd_row_b][i_rd_col_b];
  end

  // Flattened wall bitmap: row 0 in the MSBs, column 0 leftmost within a row.
  always_comb begin
    o_wall_map_out = '0;
    for (int r = 0; r < GRID_H; r++) begin
      for (int c = 0; c < GRID_W; c++) begin
        o_wall_map_out[(GRID_H-1-r)*GRID_W + (GRID_W-1-c)] = (r_grid[r][c] == WALL);
      end
    end
  end

endmodule

// File: tb/tb_tile_map_engine.sv
// Bench for tile_map_engine: directed scenarios plus random blasts, all
// checked against a cell-array model of the grid.
module tb_tile_map_engine;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   rd_row_a = '0, rd_col_a = '0, rd_row_b = '0, rd_col_b = '0;
  logic [1:0]   tile_a, tile_b;
  logic [143:0] wall_map;

  tile_map_engine_if bus();

  tile_map_engine dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .bus            (bus),
    .i_rd_row_a     (rd_row_a),
    .i_rd_col_a     (rd_col_a),
    .o_tile_a       (tile_a),
    .i_rd_row_b     (rd_row_b),
    .i_rd_col_b     (rd_col_b),
    .o_tile_b       (tile_b),
    .o_wall_map_out (wall_map)
  );

  always #5 clk = ~clk;

  localparam logic [11:0] WALL0 [12] = '{
    12'b111111111111, 12'b100000000001, 12'b101110011101, 12'b101000000101,
    12'b101010110101, 12'b100010000001, 12'b100000010001, 12'b101011010101,
    12'b101000000101, 12'b101110011101, 12'b100000000001, 12'b111111111111
  };
  localparam logic [11:0] BRICK0 [12] = '{
    12'b000000000000, 12'b000110000000, 12'b000000000000, 12'b000000000000,
    12'b000000000000, 12'b000000000000, 12'b000000000000, 12'b000000000000,
    12'b000000000000, 12'b000000000000, 12'b000000011000, 12'b000000000000
  };

  int n_checks = 0;
  int n_pass   = 0;
  int done_pulses = 0;

  int m_grid [12][12];   // 0 empty, 1 wall, 2 brick
  int m_count;

  always @(negedge clk) if (bus.blast_done === 1'b1) done_pulses++;

  task automatic check(input string tag, input logic [143:0] got, input logic [143:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic void m_load0();
    logic [11:0] w, b;
    for (int r = 0; r < 12; r++) begin
      w = WALL0[r];
      b = BRICK0[r];
      for (int c = 0; c < 12; c++) m_grid[r][c] = w[11-c] ? 1 : (b[11-c] ? 2 : 0);
    end
    m_count = 0;
  endfunction

  function automatic int m_tile(input int r, input int c);
    if (r < 0 || r >= 12 || c < 0 || c >= 12) return 1;
    return m_grid[r][c];
  endfunction

  function automatic void m_blast(input int r, input int c, input int rng);
    int dr [4] = '{-1, 1, 0, 0};
    int dc [4] = '{0, 0, -1, 1};
    int rr, cc, t;
    for (int d = 0; d < 4; d++) begin
      for (int k = 1; k <= rng; k++) begin
        rr = r + dr[d] * k;
        cc = c + dc[d] * k;
        t  = m_tile(rr, cc);
        if (t == 1) break;
        if (t == 2) begin
          m_grid[rr][cc] = 0;
          if (m_count < 255) m_count++;
          break;
        end
      end
    end
  endfunction

  function automatic logic [143:0] m_wallmap();
    logic [143:0] v = '0;
    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 12; c++) v[(11-r)*12 + (11-c)] = (m_grid[r][c] == 1);
    return v;
  endfunction

  task automatic read_a(input int r, input int c, input int exp, input string tag);
    rd_row_a = 4'(r);
    rd_col_a = 4'(c);
    #1;
    check(tag, tile_a, exp);
  endtask

  task automatic scan_grid(input string tag);
    for (int r = 0; r < 12; r++) begin
      for (int c = 0; c < 12; c++) begin
        rd_row_a = 4'(r);      rd_col_a = 4'(c);
        rd_row_b = 4'(11 - r); rd_col_b = 4'(11 - c);
        #1;
        check($sformatf("%s_A_%0d_%0d", tag, r, c), tile_a, m_tile(r, c));
        check($sformatf("%s_B_%0d_%0d", tag, 11 - r, 11 - c), tile_b, m_tile(11 - r, 11 - c));
      end
    end
    check({tag, "_wallmap"}, wall_map, m_wallmap());
    check({tag, "_count"}, bus.bricks_destroyed, m_count);
    @(negedge clk);
  endtask

  // Called on the negedge where the engine is already loading.
  task automatic wait_load(input string tag, input int hold);
    int n = 0;
    while (bus.load_busy === 1'b1 && n < 40) begin
      if (n >= hold) bus.load_start = 1'b0;
      n++;
      @(negedge clk);
    end
    bus.load_start = 1'b0;
    check({tag, "_busy_cycles"}, n, 12);
    check({tag, "_ready_after"}, bus.blast_ready, 1);
  endtask

  task automatic do_load(input int idx, input int hold, input string tag);
    bus.load_start = 1'b1;
    bus.map_index  = 4'(idx);
    @(posedge clk);
    @(negedge clk);
    m_load0();
    wait_load(tag, hold);
  endtask

  task automatic do_blast(input int r, input int c, input int rng, input string tag);
    int k;
    logic ready_leak;
    check({tag, "_ready"}, bus.blast_ready, 1);
    bus.blast_valid = 1'b1;
    bus.blast_row   = 4'(r);
    bus.blast_col   = 4'(c);
    bus.blast_range = 3'(rng);
    @(posedge clk);
    @(negedge clk);
    bus.blast_valid = 1'b0;
    m_blast(r, c, rng);
    k = 1;
    ready_leak = 1'b0;
    while (bus.blast_done !== 1'b1 && k <= 4 * rng + 2) begin
      if (bus.blast_ready !== 1'b0) ready_leak = 1'b1;
      k++;
      @(negedge clk);
    end
    check({tag, "_done_seen"}, bus.blast_done, 1);
    check({tag, "_ready_low"}, ready_leak, 0);
    if (rng == 0) check({tag, "_latency"}, k, 2);
    check({tag, "_count"}, bus.bricks_destroyed, m_count);
    @(negedge clk);
    check({tag, "_done_single"}, bus.blast_done, 0);
  endtask

  initial begin
    int pd, idx;
    bus.load_start  = 1'b0;
    bus.map_index   = '0;
    bus.blast_valid = 1'b0;
    bus.blast_row   = '0;
    bus.blast_col   = '0;
    bus.blast_range = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", bus.blast_ready, 0);
    check("rst_done", bus.blast_done, 0);
    check("rst_count", bus.bricks_destroyed, 0);
    check("rst_wallmap", wall_map, 0);
    read_a(1, 3, 0, "rst_cell_empty");
    reset = 1'b0;
    m_load0();
    wait_load("boot", 0);

    read_a(0, 0, 1, "boot_0_0_wall");
    read_a(1, 1, 0, "boot_1_1_empty");
    rd_row_b = 4'd1; rd_col_b = 4'd3; #1;
    check("boot_b_1_3_brick", tile_b, 2);
    read_a(12, 0, 1, "oob_12_0");
    read_a(0, 12, 1, "oob_0_12");
    read_a(15, 15, 1, "oob_15_15");
    @(negedge clk);
    scan_grid("boot");

    // Directed blasts.
    do_blast(1, 1, 3, "b1");
    read_a(1, 3, 0, "b1_1_3_cleared");
    read_a(1, 4, 2, "b1_1_4_kept");
    @(negedge clk);
    scan_grid("b1");
    do_blast(10, 10, 7, "b2");
    check("b2_count_two", bus.bricks_destroyed, 2);
    read_a(10, 8, 0, "b2_10_8_cleared");
    read_a(10, 7, 2, "b2_10_7_kept");
    @(negedge clk);
    scan_grid("b2");

    // Load and blast in the same cycle: load wins, out-of-range map selects map 0.
    pd = done_pulses;
    bus.load_start  = 1'b1;
    bus.map_index   = 4'd9;
    bus.blast_valid = 1'b1;
    bus.blast_row   = 4'd5;
    bus.blast_col   = 4'd5;
    bus.blast_range = 3'd3;
    @(posedge clk);
    @(negedge clk);
    bus.blast_valid = 1'b0;
    check("coll_ready_low", bus.blast_ready, 0);
    m_load0();
    wait_load("coll", 0);
    repeat (3) @(negedge clk);
    check("coll_no_done", done_pulses, pd);
    scan_grid("coll");

    // Range zero leaves the grid alone.
    do_blast(5, 5, 0, "r0");
    scan_grid("r0");

    // Load_Start held during a load must not restart it.
    do_load(0, 3, "hold");
    scan_grid("hold");

    // Random blasts with periodic reloads.
    for (int i = 0; i < 24; i++) begin
      if (i % 6 == 5) begin
        idx = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(4, 15);
        do_load(idx, 0, $sformatf("rl%0d", i));
      end
      do_blast($urandom_range(0, 13), $urandom_range(0, 13), $urandom_range(0, 7),
               $sformatf("rnd%0d", i));
      scan_grid($sformatf("rnd%0d", i));
    end

    // Reset in the middle of a blast.
    do_load(0, 0, "pre_mid");
    pd = done_pulses;
    bus.blast_valid = 1'b1;
    bus.blast_row   = 4'd1;
    bus.blast_col   = 4'd2;
    bus.blast_range = 3'd7;
    @(posedge clk);
    @(negedge clk);
    bus.blast_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_in_blast", bus.blast_ready, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_load0();
    wait_load("mid", 0);
    repeat (3) @(negedge clk);
    check("mid_no_done", done_pulses, pd);
    scan_grid("mid");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
